// File: rtl/pipe_if_stage.sv
//------------------------------------------------------------------------------
// Module  : pipe_if_stage
// Brief   : MIPS instruction-fetch stage and IF/ID register, delayed-branch,
//           ready-handshaked instruction memory with NOP bubble insertion.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  pcsource,
  input  logic        wpcir,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] dinst,
  output logic        if_bubble,
  output logic [31:0] bubble_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PEND  = 2'd2
  } state_t;

  localparam logic [31:0] C_CNT_MAX = 32'hFFFF_FFFF;

  state_t      r_state;
  logic        r_req;
  logic [31:0] r_pc;
  logic [31:0] r_redir;
  logic [31:0] r_dpc4;
  logic [31:0] r_dinst;
  logic        r_bubble;
  logic [31:0] r_cnt;

  logic        w_done;
  logic [31:0] w_pc4;
  logic [31:0] w_sel;

  assign w_done = r_req & imem_ready;
  assign w_pc4  = r_pc + 32'd4;

  // Redirect targets are word-aligned by forcing the low two bits clear.
  always_comb begin
    w_sel = w_pc4;
    case (pcsource)
      2'b01:   w_sel = {bpc[31:2], 2'b00};
      2'b10:   w_sel = {rpc[31:2], 2'b00};
      2'b11:   w_sel = {jpc[31:2], 2'b00};
      default: w_sel = w_pc4;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_BOOT;
      r_req    <= 1'b0;
      r_pc     <= RESET_PC;
      r_redir  <= 32'd0;
      r_dpc4   <= 32'd0;
      r_dinst  <= NOP_INST;
      r_bubble <= 1'b0;
      r_cnt    <= 32'd0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state  <= ST_FETCH;
          r_req    <= 1'b1;
          r_bubble <= 1'b0;
        end
        ST_FETCH, ST_PEND: begin
          if (wpcir) begin
            r_dpc4 <= w_pc4;
            if (w_done) begin
              r_dinst  <= imem_rdata;
              r_bubble <= 1'b0;
              if (r_state == ST_PEND) begin
                r_pc    <= r_redir;
                r_state <= ST_FETCH;
              end else begin
                r_pc <= w_sel;
              end
            end else begin
              r_dinst  <= NOP_INST;
              r_bubble <= 1'b1;
              if (r_cnt != C_CNT_MAX)
                r_cnt <= r_cnt + 32'd1;
              // Slow fetch of the delay slot: park the redirect until it lands.
              if (r_state == ST_FETCH && pcsource != 2'b00) begin
                r_redir <= w_sel;
                r_state <= ST_PEND;
              end
            end
          end else begin
            r_bubble <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_BOOT;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = r_req;
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign dpc4       = r_dpc4;
  assign dinst      = r_dinst;
  assign if_bubble  = r_bubble;
  assign bubble_cnt = r_cnt;

endmodule

`default_nettype wire
